// File: rtl/riscv_lsu.sv
// Load/store unit for a multicycle RV32I core: one request at a time on a valid/ack bus,
// with optional two-beat splitting of misaligned accesses and a bus-hang timeout.
module riscv_lsu #(
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1,
    parameter int TIMEOUT        = 255,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_misaligned,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

    state_t            state;
    logic              store_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              spill_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [4:0]        rd_q;
    logic [31:0]       lo_q;
    logic [CNT_W-1:0]  cnt;

    logic        illegal_in;
    logic        misal_in;
    logic [3:0]  lanes_in;
    logic [31:0] wdata_in;
    logic [3:0]  lanes2;
    logic [31:0] wdata2;
    logic [31:0] lo_shift;
    logic [31:0] hi_part;
    logic [31:0] raw;
    logic [31:0] ext;
    logic        timeout_hit;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign req_ready = (state == IDLE);

    // Decode of the incoming request, used only at the accept edge.
    always_comb begin
        illegal_in = req_store ? (req_funct3[2] | (&req_funct3[1:0]))
                               : ((req_funct3 == 3'b011) | (&req_funct3[2:1]));
        misal_in   = ((req_funct3[1:0] == 2'b01) && (&req_addr[1:0])) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        lanes_in   = size_mask(req_funct3[1:0]) << req_addr[1:0];
        wdata_in   = req_wdata << {req_addr[1:0], 3'b000};
    end

    // Second-beat lanes/data are the bytes that spilled past lane 3 in the first beat.
    always_comb begin
        lanes2   = size_mask(f3_q[1:0]) >> (3'd4 - {1'b0, off_q});
        wdata2   = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
        lo_shift = ((state == BEAT2) ? lo_q : mem_rdata) >> {off_q, 3'b000};
        hi_part  = (state == BEAT2) ? (mem_rdata << (6'd32 - {1'b0, off_q, 3'b000})) : 32'h0;
        raw      = lo_shift | hi_part;
        case (f3_q)
            3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
            3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  ext = {24'h0, raw[7:0]};
            3'b101:  ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
        timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            store_q         <= 1'b0;
            f3_q            <= 3'b000;
            off_q           <= 2'b00;
            spill_q         <= 1'b0;
            base_q          <= '0;
            wdata_q         <= 32'h0;
            rd_q            <= 5'd0;
            lo_q            <= 32'h0;
            cnt             <= '0;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'h0;
            resp_rd         <= 5'd0;
            resp_misaligned <= 1'b0;
            resp_err        <= 1'b0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_be          <= 4'b0000;
            mem_wdata       <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q <= req_store;
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        spill_q <= misal_in;
                        base_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                        wdata_q <= req_wdata;
                        rd_q    <= req_rd;
                        if (illegal_in) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rd    <= req_rd;
                        end else if (misal_in && (MISALIGN_SPLIT == 0)) begin
                            state           <= RESP;
                            resp_valid      <= 1'b1;
                            resp_misaligned <= 1'b1;
                            resp_rd         <= req_rd;
                        end else begin
                            state     <= BEAT1;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_be    <= lanes_in;
                            mem_wdata <= req_store ? wdata_in : 32'h0;
                        end
                    end
                end
                BEAT1, BEAT2: begin
                    if (mem_ack) begin
                        if (state == BEAT1 && spill_q) begin
                            state     <= BEAT2;
                            cnt       <= '0;
                            lo_q      <= mem_rdata;
                            mem_addr  <= base_q + ADDR_W'(4);
                            mem_be    <= lanes2;
                            mem_wdata <= store_q ? wdata2 : 32'h0;
                        end else begin
                            state      <= RESP;
                            mem_req    <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_addr   <= '0;
                            mem_be     <= 4'b0000;
                            mem_wdata  <= 32'h0;
                            resp_valid <= 1'b1;
                            resp_rdata <= store_q ? 32'h0 : ext;
                            resp_rd    <= rd_q;
                        end
                    end else if (timeout_hit) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= '0;
                        mem_be     <= 4'b0000;
                        mem_wdata  <= 32'h0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'h0;
                        resp_rd    <= rd_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // The response lives for exactly one cycle.
                    state           <= IDLE;
                    resp_valid      <= 1'b0;
                    resp_rdata      <= 32'h0;
                    resp_rd         <= 5'd0;
                    resp_misaligned <= 1'b0;
                    resp_err        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: a split-capable unit with a short timeout, plus a non-splitting
// instance for the misaligned-trap case. Responses are checked against a scoreboard.
module tb_riscv_lsu;

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        mis;
        logic        err;
    } resp_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_valid_ns;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_ack;
    logic        mem_ack_ns;
    logic [31:0] mem_rdata;

    logic        req_ready, resp_valid, resp_misaligned, resp_err, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [4:0]  resp_rd;
    logic [3:0]  mem_be;

    logic        req_ready_ns, resp_valid_ns, resp_misaligned_ns, resp_err_ns, mem_req_ns, mem_we_ns;
    logic [31:0] resp_rdata_ns, mem_addr_ns, mem_wdata_ns;
    logic [4:0]  resp_rd_ns;
    logic [3:0]  mem_be_ns;

    resp_t sb[$];
    resp_t mon_exp;
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  ns_req_seen = 1'b0;

    riscv_lsu #(.ADDR_W(32), .MISALIGN_SPLIT(1), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_misaligned(resp_misaligned), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    riscv_lsu #(.ADDR_W(32), .MISALIGN_SPLIT(0), .TIMEOUT(4), .CNT_W(8)) dut_ns (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_ns), .req_ready(req_ready_ns), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid_ns), .resp_rdata(resp_rdata_ns), .resp_rd(resp_rd_ns),
        .resp_misaligned(resp_misaligned_ns), .resp_err(resp_err_ns),
        .mem_req(mem_req_ns), .mem_we(mem_we_ns), .mem_addr(mem_addr_ns), .mem_be(mem_be_ns),
        .mem_wdata(mem_wdata_ns), .mem_ack(mem_ack_ns), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (mem_req_ns) ns_req_seen <= 1'b1;

    // Scoreboard: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && resp_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL unexpected_resp got rdata=%h rd=%0d mis=%b err=%b want none",
                         resp_rdata, resp_rd, resp_misaligned, resp_err);
            end else begin
                mon_exp = sb.pop_front();
                if ({resp_rdata, resp_rd, resp_misaligned, resp_err} !== mon_exp) begin
                    n_bad++;
                    $display("[TB] FAIL resp got rdata=%h rd=%0d mis=%b err=%b want rdata=%h rd=%0d mis=%b err=%b",
                             resp_rdata, resp_rd, resp_misaligned, resp_err,
                             mon_exp.rdata, mon_exp.rd, mon_exp.mis, mon_exp.err);
                end
            end
        end
    end

    task automatic issue(input logic sel_ns, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         output logic rdy);
        @(negedge clk);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        if (sel_ns) req_valid_ns = 1'b1;
        else        req_valid    = 1'b1;
        rdy = sel_ns ? req_ready_ns : req_ready;
        @(posedge clk);
        @(negedge clk);
        req_valid    = 1'b0;
        req_valid_ns = 1'b0;
    endtask

    task automatic ack_beat(input logic [31:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL %s_drain got %0d pending want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 0; req_valid_ns = 0; req_store = 0; req_funct3 = 0;
        req_addr = 0; req_wdata = 0; req_rd = 0; mem_ack = 0; mem_ack_ns = 0; mem_rdata = 0;
        #12;
        n_cmp++;
        if ({req_ready, mem_req, resp_valid} !== 3'b100) begin
            n_bad++;
            $display("[TB] FAIL reset_ctrl got ready/req/valid=%b want 100", {req_ready, mem_req, resp_valid});
        end
        n_cmp++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_bus got we=%b be=%b addr=%h wdata=%h want 0", mem_we, mem_be, mem_addr, mem_wdata);
        end
        n_cmp++;
        if ({resp_rdata, resp_rd, resp_misaligned, resp_err} !== 39'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_resp got rdata=%h rd=%0d want 0", resp_rdata, resp_rd);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_aligned_lw();
        logic rdy;
        sb.push_back('{rdata: 32'hDEADBEEF, rd: 5'd5, mis: 1'b0, err: 1'b0});
        issue(0, 0, 3'b010, 32'h100, 32'h0, 5'd5, rdy);
        n_cmp++;
        if (rdy !== 1'b1) begin n_bad++; $display("[TB] FAIL lw_ready got %b want 1", rdy); end
        n_cmp++;
        if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'b1111, 32'h100}) begin
            n_bad++;
            $display("[TB] FAIL lw_bus got req=%b we=%b be=%b addr=%h want 1 0 1111 00000100", mem_req, mem_we, mem_be, mem_addr);
        end
        ack_beat(32'hDEADBEEF);
        n_cmp++;
        if ({resp_valid, mem_req} !== 2'b10) begin
            n_bad++;
            $display("[TB] FAIL lw_latency got valid/req=%b want 10", {resp_valid, mem_req});
        end
        @(negedge clk);
        n_cmp++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL lw_after got valid/ready=%b want 01", {resp_valid, req_ready});
        end
        drain("lw");
    endtask

    task automatic test_byte_loads();
        logic rdy;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{rdata: (k == 0) ? 32'hFFFFFF80 : 32'h00000080, rd: 5'(6 + k), mis: 1'b0, err: 1'b0});
            issue(0, 0, (k == 0) ? 3'b000 : 3'b100, 32'h103, 32'h0, 5'(6 + k), rdy);
            n_cmp++;
            if ({mem_be, mem_addr} !== {4'b1000, 32'h100}) begin
                n_bad++;
                $display("[TB] FAIL byte_bus%0d got be=%b addr=%h want 1000 00000100", k, mem_be, mem_addr);
            end
            ack_beat(32'h80112233);
        end
        drain("byte");
    endtask

    task automatic test_store_sh();
        logic rdy;
        sb.push_back('{rdata: 32'h0, rd: 5'd7, mis: 1'b0, err: 1'b0});
        issue(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 5'd7, rdy);
        n_cmp++;
        if ({mem_we, mem_be, mem_wdata, mem_addr} !== {1'b1, 4'b1100, 32'hABCD0000, 32'h100}) begin
            n_bad++;
            $display("[TB] FAIL sh_bus got we=%b be=%b wdata=%h addr=%h want 1 1100 abcd0000 00000100", mem_we, mem_be, mem_wdata, mem_addr);
        end
        ack_beat(32'h0);
        drain("sh");
    endtask

    task automatic test_split();
        logic rdy;
        sb.push_back('{rdata: 32'h55443322, rd: 5'd8, mis: 1'b0, err: 1'b0});
        issue(0, 0, 3'b010, 32'h101, 32'h0, 5'd8, rdy);
        n_cmp++;
        if ({mem_be, mem_addr} !== {4'b1110, 32'h100}) begin
            n_bad++;
            $display("[TB] FAIL split_b1 got be=%b addr=%h want 1110 00000100", mem_be, mem_addr);
        end
        ack_beat(32'h44332211);
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if ({mem_req, mem_be, mem_addr} !== {1'b1, 4'b0001, 32'h104}) begin
                n_bad++;
                $display("[TB] FAIL split_b2_%0d got req=%b be=%b addr=%h want 1 0001 00000104", w, mem_req, mem_be, mem_addr);
            end
            if (w == 0) @(negedge clk);
        end
        ack_beat(32'h88776655);

        sb.push_back('{rdata: 32'h0, rd: 5'd9, mis: 1'b0, err: 1'b0});
        issue(0, 1, 3'b010, 32'h103, 32'h11223344, 5'd9, rdy);
        n_cmp++;
        if ({mem_we, mem_be, mem_wdata} !== {1'b1, 4'b1000, 32'h44000000}) begin
            n_bad++;
            $display("[TB] FAIL sw_b1 got we=%b be=%b wdata=%h want 1 1000 44000000", mem_we, mem_be, mem_wdata);
        end
        ack_beat(32'h0);
        n_cmp++;
        if ({mem_be, mem_wdata, mem_addr} !== {4'b0111, 32'h00112233, 32'h104}) begin
            n_bad++;
            $display("[TB] FAIL sw_b2 got be=%b wdata=%h addr=%h want 0111 00112233 00000104", mem_be, mem_wdata, mem_addr);
        end
        ack_beat(32'h0);

        sb.push_back('{rdata: 32'hFFFFCDAB, rd: 5'd10, mis: 1'b0, err: 1'b0});
        issue(0, 0, 3'b001, 32'hFFFFFFFF, 32'h0, 5'd10, rdy);
        n_cmp++;
        if ({mem_be, mem_addr} !== {4'b1000, 32'hFFFFFFFC}) begin
            n_bad++;
            $display("[TB] FAIL wrap_b1 got be=%b addr=%h want 1000 fffffffc", mem_be, mem_addr);
        end
        ack_beat(32'hAB000000);
        n_cmp++;
        if ({mem_be, mem_addr} !== {4'b0001, 32'h0}) begin
            n_bad++;
            $display("[TB] FAIL wrap_b2 got be=%b addr=%h want 0001 00000000", mem_be, mem_addr);
        end
        ack_beat(32'h000000CD);
        drain("split");
    endtask

    task automatic test_illegal();
        logic rdy;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{rdata: 32'h0, rd: 5'(20 + k), mis: 1'b0, err: 1'b1});
            issue(0, k[0], (k == 0) ? 3'b011 : 3'b100, 32'h100, 32'h0, 5'(20 + k), rdy);
            n_cmp++;
            if (mem_req !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL illegal%0d_req got %b want 0", k, mem_req);
            end
            @(negedge clk);
        end
        drain("illegal");
    endtask

    task automatic test_no_split();
        logic rdy;
        issue(1, 0, 3'b010, 32'h101, 32'h0, 5'd15, rdy);
        n_cmp++;
        if ({rdy, resp_valid_ns, resp_misaligned_ns, resp_err_ns, mem_req_ns} !== 5'b11100) begin
            n_bad++;
            $display("[TB] FAIL nosplit_flags got rdy/valid/mis/err/req=%b want 11100",
                     {rdy, resp_valid_ns, resp_misaligned_ns, resp_err_ns, mem_req_ns});
        end
        n_cmp++;
        if ({resp_rdata_ns, resp_rd_ns} !== {32'h0, 5'd15}) begin
            n_bad++;
            $display("[TB] FAIL nosplit_data got rdata=%h rd=%0d want 0 15", resp_rdata_ns, resp_rd_ns);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({resp_valid_ns, ns_req_seen, req_ready_ns} !== 3'b001) begin
            n_bad++;
            $display("[TB] FAIL nosplit_after got valid/seen/ready=%b want 001", {resp_valid_ns, ns_req_seen, req_ready_ns});
        end
    endtask

    task automatic test_timeout();
        logic rdy;
        int   n;
        sb.push_back('{rdata: 32'h0, rd: 5'd11, mis: 1'b0, err: 1'b1});
        issue(0, 0, 3'b010, 32'h200, 32'h0, 5'd11, rdy);
        n = 0;
        while (mem_req === 1'b1 && n < 20) begin
            n++;
            n_cmp++;
            if (mem_addr !== 32'h200) begin
                n_bad++;
                $display("[TB] FAIL timeout_hold got addr=%h want 00000200", mem_addr);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (n != 4) begin
            n_bad++;
            $display("[TB] FAIL timeout_cycles got %0d want 4", n);
        end
        drain("timeout");
        sb.push_back('{rdata: 32'hCAFEF00D, rd: 5'd12, mis: 1'b0, err: 1'b0});
        issue(0, 0, 3'b010, 32'h300, 32'h0, 5'd12, rdy);
        n_cmp++;
        if ({rdy, mem_req, mem_addr} !== {1'b1, 1'b1, 32'h300}) begin
            n_bad++;
            $display("[TB] FAIL timeout_next got rdy=%b req=%b addr=%h want 1 1 00000300", rdy, mem_req, mem_addr);
        end
        ack_beat(32'hCAFEF00D);
        drain("timeout_next");
    endtask

    task automatic test_reset_mid();
        logic rdy;
        issue(0, 0, 3'b010, 32'h400, 32'h0, 5'd13, rdy);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_req !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL rstmid_wait%0d got req=%b want 1", w, mem_req);
            end
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, resp_valid} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL rstmid_drop got req/valid=%b want 00", {mem_req, resp_valid});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rstmid_ready got %b want 1", req_ready);
        end
        sb.push_back('{rdata: 32'h12345678, rd: 5'd14, mis: 1'b0, err: 1'b0});
        issue(0, 0, 3'b010, 32'h404, 32'h0, 5'd14, rdy);
        n_cmp++;
        if ({mem_be, mem_addr} !== {4'b1111, 32'h404}) begin
            n_bad++;
            $display("[TB] FAIL rstmid_lw got be=%b addr=%h want 1111 00000404", mem_be, mem_addr);
        end
        ack_beat(32'h12345678);
        drain("rstmid");
    endtask

    initial begin
        test_reset();
        test_aligned_lw();
        test_byte_loads();
        test_store_sh();
        test_split();
        test_illegal();
        test_no_split();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Parametrised load/store unit for the next multicycle RV32I core. Takes one load/store request from the core's EXECUTE stage. Runs it on a valid/ack memory bus with byte enables, and returns sign/zero-extended load data. Unlike the current core, it tolerates variable memory latency, times out hung accesses, and either traps or splits misaligned accesses.

Parameters:
ADDR_W, 32, byte address width; all address arithmetic is modulo 2^ADDR_W.
MISALIGN_SPLIT, 1, 1 = split misaligned access into two bus beats; 0 = report misaligned, no bus cycle.
TIMEOUT, 255, max cycles mem_req may wait for mem_ack before abort; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  unit idle and can accept a request.
req_store  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
req_addr  in  ADDR_W  byte address (rs1+imm, already computed).
req_wdata  in  32  store data (rs2), unshifted.
req_rd  in  5  destination register tag.
resp_valid  out  1  single-cycle completion pulse.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_rd  out  5  tag echoed from the request.
resp_misaligned  out  1  valid with resp_valid.
resp_err  out  1  illegal funct3 or timeout; valid with resp_valid.
mem_req  out  1  bus request.
mem_we  out  1  bus write.
mem_addr  out  ADDR_W  word-aligned address (low 2 bits always 0).
mem_be  out  4  byte lane enables.
mem_wdata  out  32  lane-aligned write data.
mem_ack  in  1  slave completion, sampled when mem_req=1.
mem_rdata  in  32  read data, valid with mem_ack.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=1, mem_req=0.
  - All resp_* outputs, mem_we, mem_be, mem_wdata, mem_addr and the counter are 0.
  - Reset mid-transaction drops mem_req immediately and emits no response.
- States: IDLE, BEAT1, BEAT2, RESP.
- IDLE: req_ready=1. On req_valid, latch the request and decode it:
  - Illegal funct3 (load 011/110/111; store anything other than 000/001/010) -> RESP with resp_err=1.
  - Misaligned means halfword at offset 3 or word at offset !=0.
  - Misaligned with MISALIGN_SPLIT=0 -> RESP with resp_misaligned=1 and no bus cycle.
  - Otherwise -> BEAT1.
- BEAT1: mem_req=1, mem_addr=addr&~3.
  - Byte lanes are offset..min(offset+size-1,3).
  - mem_wdata = req_wdata << 8*offset.
  - On mem_ack: if the access spills past byte 3 go to BEAT2, else go to RESP.
- BEAT2: mem_req stays 1 and mem_addr=(addr&~3)+4, wrapping modulo 2^ADDR_W.
  - Lanes are 0..(offset+size-5).
  - mem_wdata = req_wdata >> 8*(4-offset).
  - On mem_ack -> RESP.
- Bus rule: while mem_req=1 and no ack, mem_addr, mem_we, mem_be and mem_wdata hold stable. An ack with mem_req=0 is ignored.
- Load assembly: beat-1 bytes from offset upward fill the low bytes; beat-2 bytes fill the upper bytes. The result is then sign-extended (LB/LH) or zero-extended (LBU/LHU); LW is taken as-is.
- Timeout: the counter clears on entering BEAT1/BEAT2 and increments each cycle mem_req=1 without ack. When the count reaches TIMEOUT (and TIMEOUT!=0), drop mem_req and go to RESP with resp_err=1 and resp_rdata=0.
- RESP: resp_valid=1 for exactly one cycle, resp_rd=latched tag, then IDLE. There is no back-pressure.
- Latency, aligned access with ack in the first BEAT1 cycle: request accepted at edge t, mem_req high during cycle t..t+1, resp_valid in cycle t+2, req_ready again in cycle t+3. A split access adds 1 cycle plus any wait states.
- Registered outputs: all resp_* and mem_* outputs come from registers; only req_ready decodes state.

Test Plan:
- Aligned LW addr 0x100, mem_rdata 0xDEADBEEF, ack after 0 wait -> mem_be=1111, mem_addr=0x100; resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
- LB addr 0x103, rdata 0x80112233 -> be=1000; resp_rdata=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr 0x102, wdata 0x0000ABCD -> mem_be=1100, mem_wdata=0xABCD0000, mem_we=1; resp_rdata=0.
- SPLIT=1, LW addr 0x101: beat1 addr 0x100 rdata 0x44332211 (be 1110), beat2 addr 0x104 rdata 0x88776655 (be 0001) -> resp_rdata=0x55443322. With SPLIT=0 -> resp_misaligned=1, mem_req never asserted.
- TIMEOUT=4, mem_ack held 0 -> mem_req high 4 cycles then drops; resp_err=1; next request accepted normally.
- Reset asserted while in BEAT1 with 3 wait cycles -> mem_req low immediately, no resp_valid; after release req_ready=1 and an LW completes normally.
